// File: rtl/nzr_grb_receiver.sv
// -----------------------------------------------------------------------------
// nzr_grb_receiver
//   Receive side of the single-wire NZR LED protocol. Decodes the pulse stream
//   on dataIn into 24-bit GRB pixel words (MSB first, G7 first) and detects the
//   long low latch gap that ends a frame. Doubles as a loop-back checker on an
//   LED data line and as a behavioural model of a downstream LED.
//
//   Optional feature macro: NZR_PASSTHRU_EN
//     defined     : dataOut forwards the synchronized line, gated so that the
//                   downstream device sees the frame minus its first pixel.
//     not defined : dataOut is tied low and no forwarding logic is built.
//
// Ports
//   clk         in   system clock
//   reset       in   asynchronous active-low reset
//   dataIn      in   NZR serial line, asynchronous to clk
//   pixel       out  [23:0] last decoded GRB word {G,R,B}
//   pixelValid  out  1-cycle pulse: pixel/pixelIdx updated
//   pixelIdx    out  [IDX_W-1:0] 0-based position of pixel in current frame
//   frameDone   out  1-cycle pulse: latch gap seen after >=1 bit of the frame
//   pixelCount  out  [IDX_W-1:0] whole pixels in the last completed frame
//   err         out  1-cycle pulse on any protocol error
//   dataOut     out  forwarded stream (see macro above)
//
// Handshake: pixelValid, frameDone and err are single-cycle strobes with no
//   backpressure; pixel/pixelIdx are stable from a pixelValid until the next
//   one, pixelCount from a frameDone until the next one.
// -----------------------------------------------------------------------------
module nzr_grb_receiver #(
   parameter int T_THRESH = 30,
   parameter int T_GLITCH = 4,
   parameter int T_HMAX   = 60,
   parameter int T_RESET  = 2500,
   parameter int IDX_W    = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             dataIn,
   output logic [23:0]      pixel,
   output logic             pixelValid,
   output logic [IDX_W-1:0] pixelIdx,
   output logic             frameDone,
   output logic [IDX_W-1:0] pixelCount,
   output logic             err,
   output logic             dataOut
);

   localparam int HCW = $clog2(T_HMAX + 2);
   localparam int LCW = $clog2(T_RESET + 1);

   localparam logic [HCW-1:0]   HIGH_ONE    = HCW'(1);
   localparam logic [HCW-1:0]   HIGH_MAX    = HCW'(T_HMAX);
   localparam logic [HCW-1:0]   HIGH_THRESH = HCW'(T_THRESH);
   localparam logic [HCW-1:0]   HIGH_GLITCH = HCW'(T_GLITCH);
   localparam logic [LCW-1:0]   LOW_ONE     = LCW'(1);
   localparam logic [LCW-1:0]   LOW_LAST    = LCW'(T_RESET - 1);
   localparam logic [4:0]       BIT_LAST    = 5'd24;
   localparam logic [IDX_W-1:0] IDX_ONE     = IDX_W'(1);
   localparam logic [IDX_W-1:0] IDX_MAX     = '1;

   typedef enum logic [1:0] {
      WAIT_GAP = 2'd0,
      IDLE     = 2'd1,
      HIGH     = 2'd2,
      LOW      = 2'd3
   } state_t;

   state_t           state;
   state_t           prevState;   // where a rejected glitch returns to
   logic             syncMeta;
   logic             s;           // synchronized line sample
   logic [HCW-1:0]   highCnt;
   logic [LCW-1:0]   lowCnt;
   logic [4:0]       bitCnt;
   logic [23:0]      shiftReg;
   logic [IDX_W-1:0] pixIndex;
   logic             idxFull;     // pixIndex already handed out its top value
`ifdef NZR_PASSTHRU_EN
   logic             fwd;
`endif

   // Two-flop synchronizer for the asynchronous line.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         syncMeta <= 1'b0;
         s        <= 1'b0;
      end else begin
         syncMeta <= dataIn;
         s        <= syncMeta;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= WAIT_GAP;
         prevState  <= IDLE;
         highCnt    <= '0;
         lowCnt     <= '0;
         bitCnt     <= '0;
         shiftReg   <= '0;
         pixIndex   <= '0;
         idxFull    <= 1'b0;
         pixel      <= '0;
         pixelValid <= 1'b0;
         pixelIdx   <= '0;
         frameDone  <= 1'b0;
         pixelCount <= '0;
         err        <= 1'b0;
`ifdef NZR_PASSTHRU_EN
         fwd        <= 1'b0;
`endif
      end else begin
         pixelValid <= 1'b0;
         frameDone  <= 1'b0;
         err        <= 1'b0;

         // Pixel completion runs the cycle after the 24th bit is shifted in.
         // The FSM is then in LOW with lowCnt=1, so no error or frame end can
         // coincide with it below.
         if (bitCnt == BIT_LAST) begin
            pixel      <= shiftReg;
            pixelValid <= 1'b1;
            pixelIdx   <= pixIndex;
            bitCnt     <= '0;
            if (pixIndex == IDX_MAX) begin
               // Index saturated: a pixel beyond the last position is an error.
               if (idxFull) begin
                  err <= 1'b1;
`ifdef NZR_PASSTHRU_EN
                  fwd <= 1'b0;
`endif
               end
               idxFull <= 1'b1;
            end else begin
               pixIndex <= pixIndex + IDX_ONE;
            end
`ifdef NZR_PASSTHRU_EN
            // Pixel 0 is consumed here; forward everything after it.
            if (pixIndex == '0) fwd <= 1'b1;
`endif
         end

         case (state)
            WAIT_GAP: begin
               if (s) begin
                  lowCnt <= '0;
               end else if (lowCnt == LOW_LAST) begin
                  lowCnt <= '0;
                  state  <= IDLE;
               end else begin
                  lowCnt <= lowCnt + LOW_ONE;
               end
            end

            IDLE: begin
               if (s) begin
                  highCnt   <= HIGH_ONE;
                  prevState <= IDLE;
                  state     <= HIGH;
               end
            end

            HIGH: begin
               if (s) begin
                  highCnt <= highCnt + HIGH_ONE;
                  // Next count exceeds T_HMAX: pulse too long, abandon frame.
                  if (highCnt >= HIGH_MAX) begin
                     err      <= 1'b1;
                     lowCnt   <= '0;
                     bitCnt   <= '0;
                     shiftReg <= '0;
                     pixIndex <= '0;
                     idxFull  <= 1'b0;
                     state    <= WAIT_GAP;
`ifdef NZR_PASSTHRU_EN
                     fwd      <= 1'b0;
`endif
                  end
               end else if (highCnt < HIGH_GLITCH) begin
                  // Noise: resume where we were, low count untouched.
                  state <= prevState;
               end else begin
                  shiftReg <= {shiftReg[22:0], (highCnt >= HIGH_THRESH)};
                  bitCnt   <= bitCnt + 5'd1;
                  lowCnt   <= LOW_ONE;
                  state    <= LOW;
               end
            end

            LOW: begin
               if (s) begin
                  highCnt   <= HIGH_ONE;
                  prevState <= LOW;
                  state     <= HIGH;
               end else if (lowCnt >= LOW_LAST) begin
                  // Latch gap. LOW is only ever entered after a decoded bit,
                  // so this frame always contained at least one bit.
                  frameDone  <= 1'b1;
                  pixelCount <= pixIndex;
                  if (bitCnt != '0) err <= 1'b1;
                  pixIndex   <= '0;
                  idxFull    <= 1'b0;
                  bitCnt     <= '0;
                  shiftReg   <= '0;
                  lowCnt     <= '0;
                  state      <= IDLE;
`ifdef NZR_PASSTHRU_EN
                  fwd        <= 1'b0;
`endif
               end else begin
                  lowCnt <= lowCnt + LOW_ONE;
               end
            end

            default: state <= WAIT_GAP;
         endcase
      end
   end

`ifdef NZR_PASSTHRU_EN
   assign dataOut = s & fwd;
`else
   assign dataOut = 1'b0;
`endif

endmodule
